// File: rtl/ppi8255_mode0.sv
// ppi8255_mode0 -- 8255-compatible parallel port interface, mode 0 only.
//
// Three 8-bit ports (A, B, C) whose directions come from the control word:
// A, B, C-upper and C-lower are set independently. Port C supports bit
// set/reset. Reading an output port returns its latch; reading an input
// port returns the synchronised pins. The control register is write-only.
// The CPU strobes are sampled on clk_i; each bus write commits exactly once,
// on the first clock of the strobe.
//
// Ports
//   clk_i                 system clock
//   reset_i               asynchronous reset, active high (released synchronously)
//   nCS_i                 chip select, active low
//   a0, a1                register select: 0=A 1=B 2=C 3=control
//   nIORD_i, nIOWR_i      read / write strobes, active low
//   d_i                   CPU write data
//   d_o                   CPU read data, registered; IDLE_DATA when not reading
//   a_i, b_i, c_i         port pin inputs (asynchronous)
//   a_o, b_o, c_o         port output latches
//   a_oe, b_oe            1 = port drives its pins
//   c_oe                  per-bit drive enable, [7:4] C-upper, [3:0] C-lower
module ppi8255_mode0 #(
   parameter int          SYNC_STAGES = 2,
   parameter logic [7:0]  RESET_CTRL  = 8'h9B,
   parameter logic [7:0]  IDLE_DATA   = 8'hFF
) (
   input  logic       clk_i,
   input  logic       reset_i,
   input  logic       nCS_i,
   input  logic       a0,
   input  logic       a1,
   input  logic       nIORD_i,
   input  logic       nIOWR_i,
   input  logic [7:0] d_i,
   output logic [7:0] d_o,
   input  logic [7:0] a_i,
   input  logic [7:0] b_i,
   input  logic [7:0] c_i,
   output logic [7:0] a_o,
   output logic [7:0] b_o,
   output logic [7:0] c_o,
   output logic       a_oe,
   output logic       b_oe,
   output logic [7:0] c_oe
);

   // Direction bits of the control word: {A_in, CU_in, B_in, CL_in} = D4,D3,D1,D0.
   // The mode bits have no observable effect (mode 0 only, control is
   // write-only), so only the direction bits are kept.
   localparam logic [3:0] RESET_DIR = {RESET_CTRL[4], RESET_CTRL[3],
                                       RESET_CTRL[1], RESET_CTRL[0]};

   // Reset synchroniser: asserts immediately, releases two clocks later.
   logic [1:0] rst_sync_q, rst_sync_d;
   logic       rst;

   always_comb rst_sync_d = {rst_sync_q[0], 1'b0};

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) rst_sync_q <= 2'b11;
      else         rst_sync_q <= rst_sync_d;
   end

   assign rst = rst_sync_q[1];

   // State
   logic [3:0] dir_q, dir_d;
   logic [7:0] a_o_q, a_o_d, b_o_q, b_o_d, c_o_q, c_o_d;
   logic       a_oe_q, a_oe_d, b_oe_q, b_oe_d;
   logic [7:0] c_oe_q, c_oe_d;
   logic [7:0] d_o_q, d_o_d;
   logic       wr_q, wr_d;
   logic [SYNC_STAGES-1:0][23:0] sync_q, sync_d;

   // Strobes and pin view
   logic       wr, rd, commit;
   logic [1:0] sel;
   logic [7:0] a_pin, b_pin, c_pin;
   logic       a_in, b_in, cu_in, cl_in;

   assign sel    = {a1, a0};
   assign wr     = ~nCS_i & ~nIOWR_i;
   assign rd     = ~nCS_i & ~nIORD_i;
   // wr_q tracks wr even with CS high, so releasing CS mid-strobe re-arms.
   assign commit = wr & ~wr_q;
   assign wr_d   = wr;

   assign a_in  = dir_q[3];
   assign cu_in = dir_q[2];
   assign b_in  = dir_q[1];
   assign cl_in = dir_q[0];

   assign a_pin = sync_q[SYNC_STAGES-1][23:16];
   assign b_pin = sync_q[SYNC_STAGES-1][15:8];
   assign c_pin = sync_q[SYNC_STAGES-1][7:0];

   always_comb begin
      sync_d[0] = {a_i, b_i, c_i};
      for (int i = 1; i < SYNC_STAGES; i++) sync_d[i] = sync_q[i-1];
   end

   // Register writes. Latches load regardless of direction.
   always_comb begin
      dir_d = dir_q;
      a_o_d = a_o_q;
      b_o_d = b_o_q;
      c_o_d = c_o_q;
      if (commit) begin
         case (sel)
            2'd0: a_o_d = d_i;
            2'd1: b_o_d = d_i;
            2'd2: c_o_d = d_i;
            default: begin
               if (d_i[7]) begin
                  // Mode set clears every output latch.
                  dir_d = {d_i[4], d_i[3], d_i[1], d_i[0]};
                  a_o_d = 8'h00;
                  b_o_d = 8'h00;
                  c_o_d = 8'h00;
               end else begin
                  c_o_d[d_i[3:1]] = d_i[0];
               end
            end
         endcase
      end
   end

   // Drive enables follow the stored direction one clock later.
   always_comb begin
      a_oe_d = ~a_in;
      b_oe_d = ~b_in;
      c_oe_d = {{4{~cu_in}}, {4{~cl_in}}};
   end

   // Read mux works from the pre-write state of this clock.
   always_comb begin
      d_o_d = IDLE_DATA;
      if (rd) begin
         case (sel)
            2'd0: d_o_d = a_in ? a_pin : a_o_q;
            2'd1: d_o_d = b_in ? b_pin : b_o_q;
            2'd2: d_o_d = {cu_in ? c_pin[7:4] : c_o_q[7:4],
                           cl_in ? c_pin[3:0] : c_o_q[3:0]};
            default: d_o_d = IDLE_DATA;
         endcase
      end
   end

   always_ff @(posedge clk_i or posedge rst) begin
      if (rst) begin
         dir_q  <= RESET_DIR;
         a_o_q  <= 8'h00;
         b_o_q  <= 8'h00;
         c_o_q  <= 8'h00;
         a_oe_q <= ~RESET_DIR[3];
         b_oe_q <= ~RESET_DIR[1];
         c_oe_q <= {{4{~RESET_DIR[2]}}, {4{~RESET_DIR[0]}}};
         d_o_q  <= IDLE_DATA;
         // Held high so a strobe already low at release does not commit.
         wr_q   <= 1'b1;
         sync_q <= '0;
      end else begin
         dir_q  <= dir_d;
         a_o_q  <= a_o_d;
         b_o_q  <= b_o_d;
         c_o_q  <= c_o_d;
         a_oe_q <= a_oe_d;
         b_oe_q <= b_oe_d;
         c_oe_q <= c_oe_d;
         d_o_q  <= d_o_d;
         wr_q   <= wr_d;
         sync_q <= sync_d;
      end
   end

   assign d_o  = d_o_q;
   assign a_o  = a_o_q;
   assign b_o  = b_o_q;
   assign c_o  = c_o_q;
   assign a_oe = a_oe_q;
   assign b_oe = b_oe_q;
   assign c_oe = c_oe_q;

endmodule

// File: tb/tb_ppi8255_mode0.sv
// tb_ppi8255_mode0 -- bench for ppi8255_mode0: vector table plus hand-built
// multi-cycle sequences; read data checked through a scoreboard queue.
module tb_ppi8255_mode0;
   localparam int SS = 2;

   logic       clk = 1'b0;
   logic       reset_i, nCS, a0, a1, nIORD, nIOWR;
   logic [7:0] d_i, d_o, a_i, b_i, c_i, a_o, b_o, c_o, c_oe;
   logic       a_oe, b_oe;

   ppi8255_mode0 #(.SYNC_STAGES(SS), .RESET_CTRL(8'h9B), .IDLE_DATA(8'hFF)) dut (
      .clk_i(clk), .reset_i(reset_i), .nCS_i(nCS), .a0(a0), .a1(a1),
      .nIORD_i(nIORD), .nIOWR_i(nIOWR), .d_i(d_i), .d_o(d_o),
      .a_i(a_i), .b_i(b_i), .c_i(c_i), .a_o(a_o), .b_o(b_o), .c_o(c_o),
      .a_oe(a_oe), .b_oe(b_oe), .c_oe(c_oe)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(string tag, logic [15:0] act, logic [15:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", tag, act, exp);
      end
   endtask

   // Scoreboard: expected d_o pushed when a read strobe is driven, popped on
   // the falling edge after the clock that sampled it.
   typedef struct { logic [7:0] exp; string tag; } sb_t;
   sb_t sbq[$];
   logic rd_seen = 1'b0;

   always @(posedge clk) rd_seen <= ~nCS & ~nIORD;

   always @(negedge clk) begin
      sb_t e;
      if (rd_seen) begin
         if (sbq.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL sb_underflow: read seen with no expected value");
         end else begin
            e = sbq.pop_front();
            check(e.tag, {8'h00, d_o}, {8'h00, e.exp});
         end
      end
   end

   task automatic idle();
      nCS = 1'b1; nIORD = 1'b1; nIOWR = 1'b1;
   endtask

   task automatic tick(int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic bus_wr(logic [1:0] ad, logic [7:0] dat, int hold);
      {a1, a0} = ad; d_i = dat; nCS = 1'b0; nIOWR = 1'b0;
      tick(hold);
      idle();
      tick(1);
   endtask

   task automatic bus_rd(logic [1:0] ad, logic [7:0] exp, string tag);
      {a1, a0} = ad; nCS = 1'b0; nIORD = 1'b0;
      sbq.push_back('{exp, tag});
      tick(1);
      idle();
      tick(1);
   endtask

   typedef struct {
      bit         wr;
      logic [1:0] ad;
      logic [7:0] dat, pa, pb, pc, ed, ea, eb, ec;
      logic [9:0] eoe;   // {a_oe, b_oe, c_oe}
   } vec_t;

   function automatic vec_t mk(bit w, logic [1:0] ad, logic [7:0] dat,
                               logic [7:0] pa, logic [7:0] pb, logic [7:0] pc,
                               logic [7:0] ed, logic [7:0] ea, logic [7:0] eb,
                               logic [7:0] ec, logic [9:0] eoe);
      mk = '{w, ad, dat, pa, pb, pc, ed, ea, eb, ec, eoe};
   endfunction

   vec_t tbl[24];

   initial begin
      // ctrl 80: all out; 81: C-lower in; 9B: all in; 8A: B and C-upper in
      tbl[0]  = mk(1, 3, 8'h80, 0, 0, 0, 0,     8'h00, 8'h00, 8'h00, 10'h3FF);
      tbl[1]  = mk(1, 0, 8'h3C, 0, 0, 0, 0,     8'h3C, 8'h00, 8'h00, 10'h3FF);
      tbl[2]  = mk(0, 0, 0, 8'hC3, 0, 0, 8'h3C, 8'h3C, 8'h00, 8'h00, 10'h3FF);
      tbl[3]  = mk(1, 1, 8'h99, 0, 0, 0, 0,     8'h3C, 8'h99, 8'h00, 10'h3FF);
      tbl[4]  = mk(0, 1, 0, 0, 8'h11, 0, 8'h99, 8'h3C, 8'h99, 8'h00, 10'h3FF);
      tbl[5]  = mk(1, 3, 8'h81, 0, 0, 0, 0,     8'h00, 8'h00, 8'h00, 10'h3F0);
      tbl[6]  = mk(1, 2, 8'hA5, 0, 0, 0, 0,     8'h00, 8'h00, 8'hA5, 10'h3F0);
      tbl[7]  = mk(0, 2, 0, 0, 0, 8'h0F, 8'hAF, 8'h00, 8'h00, 8'hA5, 10'h3F0);
      tbl[8]  = mk(1, 3, 8'h80, 0, 0, 0, 0,     8'h00, 8'h00, 8'h00, 10'h3FF);
      tbl[9]  = mk(1, 2, 8'h00, 0, 0, 0, 0,     8'h00, 8'h00, 8'h00, 10'h3FF);
      tbl[10] = mk(1, 3, 8'h0F, 0, 0, 0, 0,     8'h00, 8'h00, 8'h80, 10'h3FF);
      tbl[11] = mk(0, 3, 0, 0, 0, 0, 8'hFF,     8'h00, 8'h00, 8'h80, 10'h3FF);
      tbl[12] = mk(1, 3, 8'h0E, 0, 0, 0, 0,     8'h00, 8'h00, 8'h00, 10'h3FF);
      tbl[13] = mk(1, 3, 8'h05, 0, 0, 0, 0,     8'h00, 8'h00, 8'h04, 10'h3FF);
      tbl[14] = mk(1, 3, 8'h9B, 0, 0, 0, 0,     8'h00, 8'h00, 8'h00, 10'h000);
      tbl[15] = mk(1, 3, 8'h0D, 0, 0, 0, 0,     8'h00, 8'h00, 8'h40, 10'h000);
      tbl[16] = mk(0, 2, 0, 0, 0, 8'h3C, 8'h3C, 8'h00, 8'h00, 8'h40, 10'h000);
      tbl[17] = mk(1, 0, 8'h77, 0, 0, 0, 0,     8'h77, 8'h00, 8'h40, 10'h000);
      tbl[18] = mk(0, 0, 0, 8'hE1, 0, 0, 8'hE1, 8'h77, 8'h00, 8'h40, 10'h000);
      tbl[19] = mk(1, 3, 8'h8A, 0, 0, 0, 0,     8'h00, 8'h00, 8'h00, 10'h20F);
      tbl[20] = mk(1, 2, 8'h5F, 0, 0, 0, 0,     8'h00, 8'h00, 8'h5F, 10'h20F);
      tbl[21] = mk(0, 2, 0, 0, 0, 8'h90, 8'h9F, 8'h00, 8'h00, 8'h5F, 10'h20F);
      tbl[22] = mk(0, 1, 0, 0, 8'h6B, 0, 8'h6B, 8'h00, 8'h00, 8'h5F, 10'h20F);
      tbl[23] = mk(0, 0, 0, 8'h12, 0, 0, 8'h00, 8'h00, 8'h00, 8'h5F, 10'h20F);

      reset_i = 1'b1; idle(); {a1, a0} = 2'd0; d_i = 8'h00;
      a_i = 8'h00; b_i = 8'h00; c_i = 8'h00;
      tick(3);
      reset_i = 1'b0;
      tick(4);

      // Reset state
      check("rst_d_o",  {8'h00, d_o}, 16'h00FF);
      check("rst_a_o",  {8'h00, a_o}, 16'h0000);
      check("rst_b_o",  {8'h00, b_o}, 16'h0000);
      check("rst_c_o",  {8'h00, c_o}, 16'h0000);
      check("rst_oe",   {6'h00, a_oe, b_oe, c_oe}, 16'h0000);

      // Input latency: pin change shows on d_o after SS+1 clocks.
      a_i = 8'h5A; {a1, a0} = 2'd0; nCS = 1'b0; nIORD = 1'b0;
      for (int k = 0; k <= SS; k++) begin
         sbq.push_back('{(k < SS) ? 8'h00 : 8'h5A, $sformatf("sync_lat%0d", k)});
         tick(1);
      end
      idle(); tick(1);
      a_i = 8'h00;

      // Vector table
      for (int i = 0; i < 24; i++) begin
         a_i = tbl[i].pa; b_i = tbl[i].pb; c_i = tbl[i].pc;
         if (tbl[i].wr) bus_wr(tbl[i].ad, tbl[i].dat, 1);
         else begin
            tick(SS + 1);
            bus_rd(tbl[i].ad, tbl[i].ed, $sformatf("row%0d_d", i));
         end
         check($sformatf("row%0d_a_o", i), {8'h00, a_o}, {8'h00, tbl[i].ea});
         check($sformatf("row%0d_b_o", i), {8'h00, b_o}, {8'h00, tbl[i].eb});
         check($sformatf("row%0d_c_o", i), {8'h00, c_o}, {8'h00, tbl[i].ec});
         check($sformatf("row%0d_oe", i), {6'h00, a_oe, b_oe, c_oe}, {6'h00, tbl[i].eoe});
      end
      a_i = 8'h00; b_i = 8'h00; c_i = 8'h00;

      // Held strobe: only the first clock's data commits.
      bus_wr(2'd3, 8'h80, 1);
      {a1, a0} = 2'd0; d_i = 8'h3C; nCS = 1'b0; nIOWR = 1'b0;
      tick(1);
      d_i = 8'hFF;
      tick(4);
      idle(); tick(1);
      check("held_a_o",  {8'h00, a_o}, 16'h003C);
      check("held_a_oe", {15'h0, a_oe}, 16'h0001);
      tick(SS + 1);
      bus_rd(2'd0, 8'h3C, "held_rd");

      // Mode set clears latches at commit; enables follow a clock later.
      bus_wr(2'd0, 8'h55, 1);
      bus_wr(2'd1, 8'h66, 1);
      bus_wr(2'd2, 8'h77, 1);
      check("ms_pre_a_o", {8'h00, a_o}, 16'h0055);
      {a1, a0} = 2'd3; d_i = 8'h90; nCS = 1'b0; nIOWR = 1'b0;
      tick(1);
      check("ms_clr", {a_o, b_o ^ c_o}, 16'h0000);
      check("ms_c_o", {8'h00, c_o}, 16'h0000);
      check("ms_oe_old", {14'h0, a_oe, b_oe}, 16'h0003);
      tick(1);
      check("ms_oe_new", {6'h00, a_oe, b_oe, c_oe}, 16'h01FF);
      idle(); tick(1);

      // Both strobes together: read sees pre-write value, write commits.
      bus_wr(2'd1, 8'hAA, 1);
      {a1, a0} = 2'd1; d_i = 8'hBB; nCS = 1'b0; nIOWR = 1'b0; nIORD = 1'b0;
      sbq.push_back('{8'hAA, "rw_pre"});
      tick(1);
      idle(); tick(1);
      check("rw_b_o", {8'h00, b_o}, 16'h00BB);
      bus_rd(2'd1, 8'hBB, "rw_post");

      // CS high: no commit, idle read data; dropping CS mid-strobe re-arms.
      {a1, a0} = 2'd1; d_i = 8'hCC; nCS = 1'b1; nIOWR = 1'b0; nIORD = 1'b0;
      tick(2);
      check("cs_hi_b_o", {8'h00, b_o}, 16'h00BB);
      check("cs_hi_d_o", {8'h00, d_o}, 16'h00FF);
      nIORD = 1'b1; nCS = 1'b0;
      tick(1);
      check("cs_rearm_b_o", {8'h00, b_o}, 16'h00CC);
      idle(); tick(1);

      // Reset mid-write: immediate clear, no commit until strobe re-cycles.
      bus_wr(2'd3, 8'h80, 1);
      {a1, a0} = 2'd0; d_i = 8'h5A; nCS = 1'b0; nIOWR = 1'b0;
      tick(1);
      check("rmw_pre_a_o", {8'h00, a_o}, 16'h005A);
      d_i = 8'hA5;
      #2 reset_i = 1'b1;
      #1 check("rmw_async_a_o", {8'h00, a_o}, 16'h0000);
      check("rmw_async_oe", {15'h0, a_oe}, 16'h0000);
      tick(1);
      reset_i = 1'b0;
      tick(5);
      check("rmw_nocommit", {8'h00, a_o}, 16'h0000);
      nIOWR = 1'b1;
      tick(1);
      nIOWR = 1'b0;
      tick(1);
      check("rmw_recommit", {8'h00, a_o}, 16'h00A5);
      idle(); tick(2);

      check("sb_drain", sbq.size(), 16'h0000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
